// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: initiator for a single-port synchronous data RAM.
// After reset it fills every word with INIT_VAL. It then serves core
// loads and stores over valid/ready. Load data comes back on a
// registered response channel that hides the RAM's one-cycle read latency.
module ram_port_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter bit                INIT_EN  = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  // core request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  // core load-response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  // status
  output logic              init_done,
  // RAM port
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_DATA,
    ST_RSP
  } state_t;

  // The sweep counter has one extra bit, so it can count past the last
  // address without wrapping back to 0.
  localparam logic [ADDR_W:0] SWEEP_END = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              init_done_q;
  logic              accept_d;

  // Ready depends only on state. It does not depend on req_valid.
  assign req_ready = (state_q == ST_IDLE) && init_done_q;
  assign accept_d  = req_valid && req_ready;

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;

  // Main controller FSM. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT_EN ? ST_INIT : ST_IDLE;
      cnt_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          // One word per cycle. Requests are ignored because req_ready is low.
          if (cnt_q != SWEEP_END) begin
            ram_we_q   <= 1'b1;
            ram_addr_q <= cnt_q[ADDR_W-1:0];
            ram_din_q  <= INIT_VAL;
            cnt_q      <= cnt_q + CNT_ONE;
          end else begin
            ram_we_q    <= 1'b0;
            init_done_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (!init_done_q) begin
            // Sweep disabled: the first cycle out of reset opens the port.
            ram_we_q    <= 1'b0;
            init_done_q <= 1'b1;
          end else if (accept_d && req_we) begin
            // Stores stay in IDLE, so they stream at one per cycle.
            ram_we_q   <= 1'b1;
            ram_addr_q <= req_addr;
            ram_din_q  <= req_wdata;
          end else if (accept_d) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= req_addr;
            state_q    <= ST_RD_ISSUE;
          end else begin
            ram_we_q <= 1'b0;
          end
        end

        ST_RD_ISSUE: begin
          // The RAM samples ram_addr on this edge.
          state_q <= ST_RD_DATA;
        end

        ST_RD_DATA: begin
          // ram_dout now holds the word addressed at the previous edge.
          rsp_rdata_q <= ram_dout;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RSP;
        end

        ST_RSP: begin
          // Hold the response until the core takes it.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          ram_we_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Testbench for ram_port_ctrl. It models the 256x16 RAM and keeps a
// word-level reference image of the expected memory contents.
module tb_ram_port_ctrl;

  localparam int          AW    = 8;
  localparam int          DW    = 16;
  localparam logic [15:0] IVAL  = 16'hA5A5;
  localparam int          DEPTH = 256;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int errors;
  int checks;

  // Physical RAM attached to the port, and the expected image of it.
  logic [DW-1:0] ram_mem   [DEPTH];
  logic [DW-1:0] model_mem [DEPTH];

  ram_port_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .INIT_EN (1'b1),
    .INIT_VAL(IVAL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM with a one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Once the sweep completes, every word should hold the fill value.
  task automatic model_fill();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = IVAL;
  endtask

  task automatic wait_ready(input string who);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout: req_ready=%b required 1", who, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({ram_we, rsp_valid, init_done, req_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: we/vld/done/rdy=%b required 0000",
               {ram_we, rsp_valid, init_done, req_ready});
    end
    checks++;
    if (ram_addr !== 8'h00 || ram_din !== 16'h0000 || rsp_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: addr=%h din=%h rdata=%h required 0",
               ram_addr, ram_din, rsp_rdata);
    end
  endtask

  // Release reset and follow the sweep. A store request is held on
  // throughout, and it must be ignored.
  task automatic test_init_sweep(input string tag);
    int bad_sweep;
    int bad_ram;
    bad_sweep = 0;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 8'h55;
    req_wdata = 16'hDEAD;
    rst_n = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      if (ram_we !== 1'b1 || ram_addr !== AW'(k - 1) || ram_din !== IVAL ||
          req_ready !== 1'b0 || init_done !== 1'b0) begin
        if (bad_sweep == 0)
          $display("FAIL %s_sweep_edge%0d: we=%b addr=%h din=%h rdy=%b done=%b required 1 %h %h 0 0",
                   tag, k, ram_we, ram_addr, ram_din, req_ready, init_done, AW'(k - 1), IVAL);
        bad_sweep++;
      end
    end
    checks++;
    if (bad_sweep != 0) errors++;
    tick();
    req_valid = 1'b0;
    checks++;
    if (ram_we !== 1'b0 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_sweep_end: we=%b done=%b required 0 1", tag, ram_we, init_done);
    end
    model_fill();
    bad_ram = 0;
    for (int i = 0; i < DEPTH; i++) if (ram_mem[i] !== model_mem[i]) bad_ram++;
    checks++;
    if (bad_ram != 0) begin
      errors++;
      $display("FAIL %s_ram_image: %0d words differ, word55=%h required %h",
               tag, bad_ram, ram_mem[8'h55], IVAL);
    end
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready("store");
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_we = 1'b0;
    model_mem[a] = d;
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== a || ram_din !== d) begin
      errors++;
      $display("FAIL store_port: we=%b addr=%h din=%h required 1 %h %h",
               ram_we, ram_addr, ram_din, a, d);
    end
  endtask

  task automatic do_load(input logic [AW-1:0] a, input int hold);
    logic [DW-1:0] exp;
    exp = model_mem[a];
    wait_ready("load");
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = a;
    rsp_ready = (hold == 0);
    tick();
    req_valid = 1'b0;
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== a || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_issue: we=%b addr=%h rdy=%b vld=%b required 0 %h 0 0",
               ram_we, ram_addr, req_ready, rsp_valid, a);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_early: rsp_valid=%b required 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
      errors++;
      $display("FAIL load_data addr %h: vld=%b rdata=%h required 1 %h", a, rsp_valid, rsp_rdata, exp);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL load_hold%0d: vld=%b rdata=%h rdy=%b required 1 %h 0",
                 h, rsp_valid, rsp_rdata, req_ready, exp);
      end
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_drop: vld=%b rdy=%b required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_init_load();
    do_load(8'h7F, 0);
    checks++;
    if (rsp_rdata !== 16'hA5A5) begin
      errors++;
      $display("FAIL init_load_7f: rdata=%h required a5a5", rsp_rdata);
    end
  endtask

  task automatic test_store_load();
    do_store(8'h10, 16'h1234);
    do_load(8'h10, 0);
    checks++;
    if (rsp_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL store_load_10: rdata=%h required 1234", rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = DW'($urandom);
    wait_ready("b2b");
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_we = 1'b1;
      req_addr = AW'(i);
      req_wdata = d[i];
      tick();
      model_mem[i] = d[i];
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== AW'(i) || ram_din !== d[i] || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_store%0d: we=%b addr=%h din=%h rdy=%b required 1 %h %h 1",
                 i, ram_we, ram_addr, ram_din, req_ready, AW'(i), d[i]);
      end
    end
    req_valid = 1'b0;
    req_we = 1'b0;
    tick();
    checks++;
    if (ram_we !== 1'b0 || ram_din !== d[3] || ram_addr !== 8'h03) begin
      errors++;
      $display("FAIL b2b_idle: we=%b din=%h addr=%h required 0 %h 03", ram_we, ram_din, ram_addr, d[3]);
    end
    for (int i = 0; i < 4; i++) do_load(AW'(i), 0);
  endtask

  task automatic test_rsp_hold();
    do_store(8'h20, DW'($urandom));
    do_load(8'h20, 3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      a = AW'(8'h40 + $urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) do_store(a, DW'($urandom));
      else do_load(a, $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_load();
    wait_ready("midrst");
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 8'h10;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || ram_we !== 1'b0 || init_done !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: vld=%b we=%b done=%b rdy=%b required 0 0 0 0",
               rsp_valid, ram_we, init_done, req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_lost_rsp: rsp_valid=%b required 0", rsp_valid);
    end
    test_init_sweep("resweep");
    do_load(8'h10, 0);
    checks++;
    if (rsp_rdata !== IVAL) begin
      errors++;
      $display("FAIL resweep_load_10: rdata=%h required %h", rsp_rdata, IVAL);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = 16'hFFFF;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'hFFFF;
    test_reset();
    test_init_sweep("sweep");
    test_init_load();
    test_store_load();
    test_back_to_back();
    test_rsp_hold();
    test_random();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
